// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } txq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with level counter and synchronous flush.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [LW-1:0]    level_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_empty;
    logic             w_full;
    logic             w_wr;
    logic             w_rd;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LW'(DEPTH));

    // Full rejects writes even when a read happens in the same cycle.
    assign w_wr = wr_en_i && !w_full && !flush_i;
    assign w_rd = rd_en_i && !w_empty && !flush_i;

    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[r_wr_ptr] <= wr_data_i;
    end

    // Pointers are exactly AW bits wide, so wrap falls out of the power-of-two depth.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign rd_data_o = r_mem[r_rd_ptr];
    assign level_o   = r_level;
    assign empty_o   = w_empty;
    assign full_o    = w_full;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue in front of the UART transmitter: valid/ready intake, one start
// pulse per byte, next byte launched only after the transmitter reports done.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic [UART_DATA_W-1:0] wr_data_i,
    input  logic                   wr_valid_i,
    output logic                   wr_ready_o,
    output logic [LW-1:0]          level_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic                   overflow_o,
    input  logic                   clr_overflow_i,
    output logic [UART_DATA_W-1:0] tx_data_o,
    output logic                   tx_start_o,
    input  logic                   tx_busy_i,
    input  logic                   tx_done_i,
    output logic                   idle_o
);

    txq_state_t             r_state;
    txq_state_t             w_state_nxt;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_ovf_set;
    logic [UART_DATA_W-1:0] w_head;
    logic [UART_DATA_W-1:0] r_tx_data;
    logic                   r_tx_start;
    logic                   r_ovf;

    assign wr_ready_o = !w_full && !flush_i;
    assign w_push     = wr_valid_i && wr_ready_o;
    assign w_ovf_set  = wr_valid_i && w_full && !flush_i;

    sync_fifo #(
        .WIDTH(UART_DATA_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .flush_i  (flush_i),
        .wr_en_i  (w_push),
        .wr_data_i(wr_data_i),
        .rd_en_i  (w_pop),
        .rd_data_o(w_head),
        .level_o  (level_o),
        .empty_o  (w_empty),
        .full_o   (w_full)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !tx_busy_i && !flush_i) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: w_state_nxt = S_WAIT;
            S_WAIT:   if (tx_done_i) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Start is registered off the next state so it lines up with the S_LAUNCH cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_start <= (w_state_nxt == S_LAUNCH);
            if (w_pop) r_tx_data <= w_head;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)             r_ovf <= 1'b0;
        else if (w_ovf_set)      r_ovf <= 1'b1;
        else if (clr_overflow_i) r_ovf <= 1'b0;
    end

    assign empty_o    = w_empty;
    assign full_o     = w_full;
    assign overflow_o = r_ovf;
    assign tx_data_o  = r_tx_data;
    assign tx_start_o = r_tx_start;
    assign idle_o     = w_empty && (r_state == S_IDLE);

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: table vectors, directed corner cases
// and randomized traffic against a queue-based reference model.
module tb_uart_tx_queue;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic [7:0]    wr_data_i;
    logic          wr_valid_i;
    logic          wr_ready_o;
    logic [LW-1:0] level_o;
    logic          empty_o;
    logic          full_o;
    logic          overflow_o;
    logic          clr_overflow_i;
    logic [7:0]    tx_data_o;
    logic          tx_start_o;
    logic          tx_busy_i;
    logic          tx_done_i;
    logic          idle_o;

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .wr_data_i     (wr_data_i),
        .wr_valid_i    (wr_valid_i),
        .wr_ready_o    (wr_ready_o),
        .level_o       (level_o),
        .empty_o       (empty_o),
        .full_o        (full_o),
        .overflow_o    (overflow_o),
        .clr_overflow_i(clr_overflow_i),
        .tx_data_o     (tx_data_o),
        .tx_start_o    (tx_start_o),
        .tx_busy_i     (tx_busy_i),
        .tx_done_i     (tx_done_i),
        .idle_o        (idle_o)
    );

    always #5 clk_i = ~clk_i;

    int         chk_cnt  = 0;
    int         pass_cnt = 0;
    int         cyc      = 0;
    int         start_cnt = 0;
    int         tx_cnt   = 0;
    int         fl_len   = 3;
    bit         force_busy = 0;
    // Reference model state: bytes queued, frame in flight, last launched byte, overflow.
    logic [7:0] ref_q[$];
    bit         outst    = 0;
    logic [7:0] exp_data = 8'h00;
    bit         exp_ovf  = 0;
    int         start_cyc[$];
    logic [7:0] start_data[$];

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       clr;
        int         lvl;
        logic       full;
        logic       ovf;
    } vec_t;
    vec_t tbl[20];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // One clock: drive inputs plus transmitter model, predict, clock, compare.
    task automatic cycle(input bit wv, input logic [7:0] wd, input bit fl, input bit clr);
        bit done, busy, acc, pstart, set_ovf;
        done = (tx_cnt == 1);
        busy = force_busy || (tx_cnt > 0);
        wr_valid_i = wv; wr_data_i = wd; flush_i = fl; clr_overflow_i = clr;
        tx_busy_i = busy; tx_done_i = done;
        #1;
        check("wr_ready", wr_ready_o, (ref_q.size() < DEPTH) && !fl);
        pstart  = !outst && (ref_q.size() > 0) && !busy && !fl;
        acc     = wv && (ref_q.size() < DEPTH) && !fl;
        set_ovf = wv && (ref_q.size() == DEPTH) && !fl;
        if (pstart) exp_data = ref_q.pop_front();
        if (fl) ref_q.delete();
        else if (acc) ref_q.push_back(wd);
        outst = pstart ? 1'b1 : (done ? 1'b0 : outst);
        if (set_ovf) exp_ovf = 1'b1;
        else if (clr) exp_ovf = 1'b0;
        @(posedge clk_i); #1;
        cyc++;
        check("tx_start", tx_start_o, pstart);
        check("tx_data",  tx_data_o,  exp_data);
        check("level",    level_o,    ref_q.size());
        check("empty",    empty_o,    ref_q.size() == 0);
        check("full",     full_o,     ref_q.size() == DEPTH);
        check("overflow", overflow_o, exp_ovf);
        check("idle",     idle_o,     (ref_q.size() == 0) && !outst);
        if (tx_cnt > 0) tx_cnt--;
        if (tx_start_o) begin
            tx_cnt = fl_len;
            start_cnt++;
            start_cyc.push_back(cyc);
            start_data.push_back(tx_data_o);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        int c0, snap, sent, lim;
        logic [7:0] sent_q[$];

        for (int i = 0; i < 16; i++)
            tbl[i] = '{wv: 1'b1, wd: 8'(i + 1), clr: 1'b0, lvl: i + 1, full: (i == 15), ovf: 1'b0};
        tbl[16] = '{wv: 1'b1, wd: 8'h11, clr: 1'b1, lvl: 16, full: 1'b1, ovf: 1'b1};
        tbl[17] = '{wv: 1'b0, wd: 8'h00, clr: 1'b1, lvl: 16, full: 1'b1, ovf: 1'b0};
        tbl[18] = '{wv: 1'b1, wd: 8'h22, clr: 1'b0, lvl: 16, full: 1'b1, ovf: 1'b1};
        tbl[19] = '{wv: 1'b0, wd: 8'h00, clr: 1'b1, lvl: 16, full: 1'b1, ovf: 1'b0};

        rst_ni = 1'b0; flush_i = 0; wr_data_i = 0; wr_valid_i = 0;
        clr_overflow_i = 0; tx_busy_i = 0; tx_done_i = 0;
        #3;
        check("rst_level", level_o, 0);
        check("rst_empty", empty_o, 1);
        check("rst_full", full_o, 0);
        check("rst_ready", wr_ready_o, 1);
        check("rst_ovf", overflow_o, 0);
        check("rst_data", tx_data_o, 8'h00);
        check("rst_start", tx_start_o, 0);
        check("rst_idle", idle_o, 1);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // Single byte: start exactly two cycles after the handshake.
        fl_len = 3;
        start_cyc.delete(); start_data.delete();
        c0 = cyc;
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        idle_cycles(6);
        check("t1_starts", start_cyc.size(), 1);
        if (start_cyc.size() == 1) begin
            check("t1_latency", start_cyc[0] - c0, 2);
            check("t1_data", start_data[0], 8'hA5);
        end
        check("t1_idle", idle_o, 1);
        check("t1_level", level_o, 0);

        // Burst to full and overflow/clear corners with the transmitter held busy.
        force_busy = 1;
        foreach (tbl[i]) begin
            cycle(tbl[i].wv, tbl[i].wd, 1'b0, tbl[i].clr);
            check("tbl_level", level_o, tbl[i].lvl);
            check("tbl_full", full_o, tbl[i].full);
            check("tbl_ovf", overflow_o, tbl[i].ovf);
        end
        check("tbl_ready_full", wr_ready_o, 0);
        force_busy = 0;
        start_cyc.delete(); start_data.delete();
        for (int k = 0; k < 300 && start_cyc.size() < 16; k++) idle_cycles(1);
        check("drain_count", start_cyc.size(), 16);
        if (start_cyc.size() == 16) begin
            for (int i = 0; i < 16; i++) check("drain_order", start_data[i], i + 1);
            for (int i = 1; i < 16; i++) check("drain_spacing", start_cyc[i] - start_cyc[i-1], fl_len + 1);
        end
        idle_cycles(6);

        // Flush while a frame is in flight, with a write offered on the flush cycle.
        force_busy = 1;
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        force_busy = 0;
        fl_len = 8;
        snap = start_cnt;
        for (int k = 0; k < 20 && start_cnt == snap; k++) idle_cycles(1);
        check("fl_launched", start_cnt - snap, 1);
        idle_cycles(1);
        check("fl_level_before", level_o, 5);
        cycle(1'b1, 8'h99, 1'b1, 1'b0);
        idle_cycles(20);
        check("fl_one_start", start_cnt - snap, 1);
        check("fl_level", level_o, 0);
        check("fl_ovf", overflow_o, 0);
        check("fl_idle", idle_o, 1);

        // Throttled stream of 40 bytes wrapping the pointers.
        fl_len = 3;
        start_data.delete(); sent_q.delete();
        sent = 0;
        lim = 0;
        while ((sent < 40 || start_data.size() < 40) && lim < 3000) begin
            bit wv;
            logic [7:0] d;
            wv = (sent < 40) && (ref_q.size() < 12) && ($urandom_range(0, 3) != 0);
            d  = 8'($urandom);
            if (wv) begin sent_q.push_back(d); sent++; end
            cycle(wv, d, 1'b0, 1'b0);
            lim++;
        end
        check("wrap_count", start_data.size(), 40);
        if (start_data.size() == 40)
            for (int i = 0; i < 40; i++) check("wrap_order", start_data[i], sent_q[i]);
        check("wrap_ovf", overflow_o, 0);
        idle_cycles(6);

        // Randomized soak over all inputs.
        for (int k = 0; k < 400; k++) begin
            force_busy = ($urandom_range(0, 4) == 0);
            fl_len = $urandom_range(2, 5);
            cycle($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) == 0);
        end
        force_busy = 0;
        fl_len = 3;
        idle_cycles(120);

        // Reset asserted in the launch cycle with three bytes still queued.
        force_busy = 1;
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
        force_busy = 0;
        for (int k = 0; k < 20 && !tx_start_o; k++) idle_cycles(1);
        check("rl_launch_seen", tx_start_o, 1);
        check("rl_level_pre", level_o, 3);
        rst_ni = 1'b0;
        #1;
        check("rl_start", tx_start_o, 0);
        check("rl_level", level_o, 0);
        check("rl_data", tx_data_o, 8'h00);
        check("rl_idle", idle_o, 1);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        ref_q.delete(); outst = 0; exp_data = 8'h00; exp_ovf = 0; tx_cnt = 0;
        snap = start_cnt;
        idle_cycles(12);
        check("rl_no_start", start_cnt - snap, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
